imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the instruction fetch interface.
- Accepts fetch addresses from the fetch stage and returns the 32-bit instruction word with one-cycle registered latency.
- Contains a word-addressed instruction RAM plus a byte-serial boot loader that fills the RAM before the core runs.
- Flags misaligned and out-of-range fetches; returns a NOP on error or while loading.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit instruction words; power of two, at least 4.
- NOP_WORD, 32'h00000013, word returned on error, during load, and after reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- instr_addr_i  in  32  byte address driven by the fetch stage.
- instr_req_i  in  1  fetch request valid this cycle.
- instr_o  out  32  instruction word for the request of the previous cycle.
- instr_valid_o  out  1  instr_o holds a valid response.
- instr_err_o  out  1  last response was misaligned or out of range.
- ld_start_i  in  1  one-cycle pulse that starts a boot load.
- ld_len_i  in  16  number of words to load; sampled on ld_start_i.
- ld_valid_i  in  1  ld_byte_i is valid.
- ld_byte_i  in  8  boot byte, little-endian within each word.
- ld_ready_o  out  1  loader will accept a byte this cycle.
- ld_done_o  out  1  one-cycle pulse when the load completes.
- busy_o  out  1  high while in LOAD.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: instr_o=NOP_WORD, instr_valid_o=0, instr_err_o=0, ld_ready_o=0, ld_done_o=0, busy_o=0.
  - State goes to SERVE; byte counter, word counter and write pointer clear to 0.
  - RAM contents are unchanged.
  - A reset during LOAD aborts the load. Words already written stay; the partial word is discarded; ld_done_o is not pulsed.
- States: SERVE, LOAD.
- SERVE, fetch path:
  - On a cycle with instr_req_i=1, the next cycle drives instr_valid_o=1.
  - Index = instr_addr_i[log2(DEPTH_WORDS)+1:2].
  - If instr_addr_i[1:0]!=0, or instr_addr_i[31:2] >= DEPTH_WORDS: instr_o=NOP_WORD and instr_err_o=1.
  - Otherwise: instr_o=RAM[index] and instr_err_o=0.
  - instr_req_i=0: instr_valid_o=0 and instr_err_o=0 next cycle; instr_o holds its last value.
  - Back-to-back requests give one response per cycle with no bubbles; latency is exactly 1.
- SERVE to LOAD:
  - On ld_start_i=1, latch len = min(ld_len_i, DEPTH_WORDS) and clear all counters.
  - If len==0: stay in SERVE and pulse ld_done_o on the next cycle.
  - If ld_start_i and instr_req_i arrive together, the fetch is still answered from the pre-load RAM.
- LOAD:
  - busy_o=1, ld_ready_o=1.
  - Fetch requests get instr_valid_o=0 and instr_o=NOP_WORD; requests are dropped, not queued.
  - Each cycle with ld_valid_i=1 shifts ld_byte_i into byte lane byte_cnt (lane 0 = bits 7:0) and increments byte_cnt (2 bits).
  - On the 4th byte, write the assembled word to RAM[word_cnt] in the same cycle, then increment word_cnt and wrap byte_cnt to 0.
  - When word_cnt reaches len after a write: return to SERVE, pulse ld_done_o for one cycle (the cycle after the final write), drop ld_ready_o and busy_o.
  - ld_start_i during LOAD is ignored.
  - ld_valid_i in SERVE is ignored.
- Write/read hazard: a word written in LOAD is readable by the first fetch accepted in SERVE, with no stale data.
- Counter widths:
  - word_cnt holds 0 to DEPTH_WORDS inclusive.
  - len comparison is unsigned, 17 bits.

Test Plan:
- Reset, then idle: instr_o=32'h00000013, instr_valid_o=0, busy_o=0. Assert rst mid-load after 6 bytes: state returns to SERVE, word 0 is kept, the partial word 1 is not written, and there is no ld_done_o.
- Boot load with ld_len_i=2 and bytes 93,00,10,00,13,01,20,00. Then fetch 0x0 and 0x4 on consecutive cycles: responses 32'h00100093 then 32'h00200113, valid on cycles +1 and +2. ld_done_o pulses exactly once.
- Misaligned fetch 0x6: next cycle instr_o=NOP_WORD, instr_err_o=1, instr_valid_o=1.
- Out-of-range fetch 0x1000 with DEPTH_WORDS=1024: instr_o=NOP_WORD, instr_err_o=1. Fetch of 0xFFC (last word): instr_err_o=0.
- Fetch during LOAD: instr_valid_o stays 0 throughout. ld_start_i pulsed mid-load leaves len and counters unchanged.
- ld_len_i=0: ld_done_o pulses the next cycle, busy_o never rises. ld_len_i=2000: load stops after 1024 words, and ld_done_o pulses after word 1023 is written.

Source files
------------

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch and boot-load signal bundle between the core side and the instruction memory
interface imem_responder_if;
  logic [31:0] instr_addr_i;
  logic        instr_req_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_err_o;
  logic        ld_start_i;
  logic [15:0] ld_len_i;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic        busy_o;

  modport slave (
    input  instr_addr_i, instr_req_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
    output instr_o, instr_valid_o, instr_err_o, ld_ready_o, ld_done_o, busy_o
  );

  modport master (
    output instr_addr_i, instr_req_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
    input  instr_o, instr_valid_o, instr_err_o, ld_ready_o, ld_done_o, busy_o
  );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction RAM with one-cycle fetch responses and a byte-serial boot loader
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  imem_responder_if.slave  bus
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [16:0] DEPTH_LEN = 17'(DEPTH_WORDS);

  typedef enum logic {SERVE, LOAD} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [AW:0] word_cnt;
  logic [16:0] len;
  logic [23:0] asm_q;
  logic [31:0] instr_q;
  logic        valid_q, err_q, done_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [16:0]   len_req;
  logic          word_wr, last_wr, done_next, fetch_err;
  logic [31:0]   wr_word;
  logic [AW-1:0] rd_idx;

  always_comb begin
    len_req   = ({1'b0, bus.ld_len_i} > DEPTH_LEN) ? DEPTH_LEN : {1'b0, bus.ld_len_i};
    word_wr   = (state == LOAD) && bus.ld_valid_i && (byte_cnt == 2'd3);
    last_wr   = word_wr && ((17'(word_cnt) + 17'd1) == len);
    wr_word   = {bus.ld_byte_i, asm_q};
    fetch_err = (bus.instr_addr_i[1:0] != 2'b00) ||
                ({2'b00, bus.instr_addr_i[31:2]} >= 32'(DEPTH_WORDS));
    rd_idx    = bus.instr_addr_i[AW+1:2];
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      SERVE: begin
        if (bus.ld_start_i) begin
          if (len_req == 17'd0) done_next = 1'b1;
          else                  state_next = LOAD;
        end
      end
      LOAD: begin
        if (last_wr) begin
          state_next = SERVE;
          done_next  = 1'b1;
        end
      end
      default: state_next = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SERVE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      len      <= '0;
      asm_q    <= '0;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_next;
      if (state == SERVE) begin
        valid_q <= bus.instr_req_i;
        if (bus.instr_req_i) begin
          err_q   <= fetch_err;
          instr_q <= fetch_err ? NOP_WORD : mem[rd_idx];
        end else begin
          err_q <= 1'b0;
        end
        if (bus.ld_start_i) begin
          len      <= len_req;
          byte_cnt <= '0;
          word_cnt <= '0;
        end
      end else begin
        // fetches are dropped while loading; a new ld_start_i is ignored here
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        instr_q <= NOP_WORD;
        if (bus.ld_valid_i) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) word_cnt <= word_cnt + 1'b1;
          else                  asm_q[8*byte_cnt +: 8] <= bus.ld_byte_i;
        end
      end
    end
  end

  // RAM has no reset so contents survive a reset; a reset edge suppresses any pending write
  always_ff @(posedge clk) begin
    if (word_wr && !rst) mem[word_cnt[AW-1:0]] <= wr_word;
  end

  assign bus.instr_o       = instr_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.instr_err_o   = err_q;
  assign bus.ld_done_o     = done_q;
  assign bus.busy_o        = (state == LOAD);
  assign bus.ld_ready_o    = (state == LOAD);
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder
module tb_imem_responder;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  imem_responder_if bus ();

  imem_responder #(.DEPTH_WORDS(1024), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [15:0] n);
    bus.ld_start_i = 1'b1;
    bus.ld_len_i   = n;
    tick();
    bus.ld_start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.instr_o !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", bus.instr_o, NOP); end
    checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid_o); end
    checks++; if (bus.instr_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.instr_err_o); end
    checks++; if ({bus.busy_o, bus.ld_ready_o, bus.ld_done_o} !== 3'b000) begin errors++; $display("FAIL reset_ld got %b want 000", {bus.busy_o, bus.ld_ready_o, bus.ld_done_o}); end
    tick();
    checks++; if ({bus.instr_valid_o, bus.busy_o} !== 2'b00 || bus.instr_o !== NOP) begin errors++; $display("FAIL idle got v/b=%b instr=%h want 00 %h", {bus.instr_valid_o, bus.busy_o}, bus.instr_o, NOP); end
  endtask

  task automatic test_boot_load();
    logic [7:0] bytes [8];
    int dones;
    bytes = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    dones = 0;
    start_load(16'd2);
    checks++; if ({bus.busy_o, bus.ld_ready_o} !== 2'b11) begin errors++; $display("FAIL load_busy got %b want 11", {bus.busy_o, bus.ld_ready_o}); end
    for (int i = 0; i < 8; i++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_byte_i  = bytes[i];
      tick();
      dones += int'(bus.ld_done_o);
    end
    bus.ld_valid_i = 1'b0;
    checks++; if ({bus.ld_done_o, bus.busy_o, bus.ld_ready_o} !== 3'b100) begin errors++; $display("FAIL load_end got %b want 100", {bus.ld_done_o, bus.busy_o, bus.ld_ready_o}); end
    tick();
    dones += int'(bus.ld_done_o);
    tick();
    dones += int'(bus.ld_done_o);
    checks++; if (dones !== 1) begin errors++; $display("FAIL load_done_count got %0d want 1", dones); end
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0;
    tick();
    bus.instr_addr_i = 32'h4;
    checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h00100093 || bus.instr_err_o !== 1'b0) begin errors++; $display("FAIL fetch0 got v=%b %h want 1 00100093", bus.instr_valid_o, bus.instr_o); end
    tick();
    bus.instr_req_i = 1'b0;
    checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h00200113) begin errors++; $display("FAIL fetch4 got v=%b %h want 1 00200113", bus.instr_valid_o, bus.instr_o); end
    tick();
    checks++; if (bus.instr_valid_o !== 1'b0 || bus.instr_o !== 32'h00200113) begin errors++; $display("FAIL fetch_hold got v=%b %h want 0 00200113", bus.instr_valid_o, bus.instr_o); end
  endtask

  task automatic test_misaligned();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h6;
    tick();
    bus.instr_req_i = 1'b0;
    checks++; if ({bus.instr_valid_o, bus.instr_err_o} !== 2'b11 || bus.instr_o !== NOP) begin errors++; $display("FAIL misaligned got v/e=%b %h want 11 %h", {bus.instr_valid_o, bus.instr_err_o}, bus.instr_o, NOP); end
    tick();
    checks++; if ({bus.instr_valid_o, bus.instr_err_o} !== 2'b00) begin errors++; $display("FAIL err_clear got %b want 00", {bus.instr_valid_o, bus.instr_err_o}); end
  endtask

  task automatic test_fetch_during_load();
    logic [7:0] bytes [4];
    int seen_valid;
    bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    seen_valid = 0;
    start_load(16'd1);
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_byte_i  = bytes[i];
      bus.ld_start_i = (i == 2);
      bus.ld_len_i   = 16'd5;
      tick();
      seen_valid += int'(bus.instr_valid_o);
      if (i == 1) begin
        checks++; if (bus.instr_o !== NOP) begin errors++; $display("FAIL load_instr got %h want %h", bus.instr_o, NOP); end
      end
    end
    bus.ld_start_i  = 1'b0;
    bus.ld_valid_i  = 1'b0;
    bus.instr_req_i = 1'b0;
    checks++; if (seen_valid !== 0) begin errors++; $display("FAIL load_fetch_valid got %0d want 0", seen_valid); end
    checks++; if ({bus.ld_done_o, bus.busy_o} !== 2'b10) begin errors++; $display("FAIL restart_ignored got %b want 10", {bus.ld_done_o, bus.busy_o}); end
    bus.instr_req_i = 1'b1;
    tick();
    bus.instr_req_i = 1'b0;
    checks++; if (bus.instr_o !== 32'h12345678) begin errors++; $display("FAIL load_word got %h want 12345678", bus.instr_o); end
  endtask

  task automatic test_start_with_fetch();
    logic [7:0] bytes [4];
    bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0;
    start_load(16'd1);
    bus.instr_req_i = 1'b0;
    checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h12345678 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL start_fetch got v=%b %h b=%b want 1 12345678 1", bus.instr_valid_o, bus.instr_o, bus.busy_o); end
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_byte_i  = bytes[i];
      tick();
    end
    bus.ld_valid_i  = 1'b0;
    bus.instr_req_i = 1'b1;
    tick();
    bus.instr_req_i = 1'b0;
    checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'hDEADBEEF) begin errors++; $display("FAIL hazard got v=%b %h want 1 deadbeef", bus.instr_valid_o, bus.instr_o); end
  endtask

  task automatic test_abort();
    logic [7:0] bytes [6];
    int dones;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    dones = 0;
    start_load(16'd2);
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_byte_i  = bytes[i];
      tick();
      dones += int'(bus.ld_done_o);
    end
    bus.ld_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dones += int'(bus.ld_done_o);
    checks++; if ({bus.busy_o, bus.ld_ready_o} !== 2'b00) begin errors++; $display("FAIL abort_state got %b want 00", {bus.busy_o, bus.ld_ready_o}); end
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0;
    tick();
    dones += int'(bus.ld_done_o);
    bus.instr_addr_i = 32'h4;
    checks++; if (bus.instr_o !== 32'h44332211) begin errors++; $display("FAIL abort_word0 got %h want 44332211", bus.instr_o); end
    tick();
    dones += int'(bus.ld_done_o);
    bus.instr_req_i = 1'b0;
    checks++; if (bus.instr_o !== 32'h00200113) begin errors++; $display("FAIL abort_word1 got %h want 00200113", bus.instr_o); end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", dones); end
  endtask

  task automatic test_len_zero();
    start_load(16'd0);
    checks++; if ({bus.ld_done_o, bus.busy_o} !== 2'b10) begin errors++; $display("FAIL len0_pulse got %b want 10", {bus.ld_done_o, bus.busy_o}); end
    tick();
    checks++; if ({bus.ld_done_o, bus.busy_o} !== 2'b00) begin errors++; $display("FAIL len0_after got %b want 00", {bus.ld_done_o, bus.busy_o}); end
  endtask

  task automatic test_len_clamp();
    logic [31:0] w;
    int dones;
    dones = 0;
    start_load(16'd2000);
    for (int i = 0; i < 1024; i++) begin
      w = 32'hC0DE0000 | 32'(i);
      for (int b = 0; b < 4; b++) begin
        if (i == 1023 && b == 3) begin
          checks++; if (dones !== 0 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL clamp_early got dones=%0d busy=%b want 0 1", dones, bus.busy_o); end
        end
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = w[8*b +: 8];
        tick();
        dones += int'(bus.ld_done_o);
      end
    end
    checks++; if ({bus.ld_done_o, bus.busy_o, bus.ld_ready_o} !== 3'b100) begin errors++; $display("FAIL clamp_done got %b want 100", {bus.ld_done_o, bus.busy_o, bus.ld_ready_o}); end
    bus.ld_byte_i = 8'hFF;
    tick();
    bus.ld_valid_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL clamp_ignore got busy=%b want 0", bus.busy_o); end
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'hFFC;
    tick();
    bus.instr_addr_i = 32'h1000;
    checks++; if (bus.instr_err_o !== 1'b0 || bus.instr_o !== 32'hC0DE03FF) begin errors++; $display("FAIL last_word got e=%b %h want 0 c0de03ff", bus.instr_err_o, bus.instr_o); end
    tick();
    bus.instr_addr_i = 32'h800;
    checks++; if ({bus.instr_valid_o, bus.instr_err_o} !== 2'b11 || bus.instr_o !== NOP) begin errors++; $display("FAIL out_of_range got v/e=%b %h want 11 %h", {bus.instr_valid_o, bus.instr_err_o}, bus.instr_o, NOP); end
    tick();
    bus.instr_req_i = 1'b0;
    checks++; if (bus.instr_err_o !== 1'b0 || bus.instr_o !== 32'hC0DE0200) begin errors++; $display("FAIL mid_word got e=%b %h want 0 c0de0200", bus.instr_err_o, bus.instr_o); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL clamp_done_count got %0d want 1", dones); end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    rst              = 1'b1;
    bus.instr_addr_i = 32'h0;
    bus.instr_req_i  = 1'b0;
    bus.ld_start_i   = 1'b0;
    bus.ld_len_i     = 16'd0;
    bus.ld_valid_i   = 1'b0;
    bus.ld_byte_i    = 8'h00;
    test_reset();
    test_boot_load();
    test_misaligned();
    test_abort();
    test_fetch_during_load();
    test_start_with_fetch();
    test_len_zero();
    test_len_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
